// File: rtl/ext_inst_injector_if.sv
// ext_inst_injector_if: source stream, core handshake and status bundle for the instruction injector.
interface ext_inst_injector_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                         s_valid;
    logic [31:0]                  s_inst;
    logic                         s_ready;
    logic [3:0]                   core_state;
    logic [31:0]                  ext_inst;
    logic                         ext_inst_en;
    logic                         busy;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;
    logic                         done_pulse;
    logic [CNT_W-1:0]             issued_cnt;
    logic                         clr_err;
    logic                         timeout_err;

    modport master (
        output s_valid, s_inst, core_state, clr_err,
        input  s_ready, ext_inst, ext_inst_en, busy, fifo_count, done_pulse, issued_cnt, timeout_err
    );

    modport slave (
        input  s_valid, s_inst, core_state, clr_err,
        output s_ready, ext_inst, ext_inst_en, busy, fifo_count, done_pulse, issued_cnt, timeout_err
    );
endinterface

// File: rtl/ext_inst_injector.sv
// ext_inst_injector: FIFO-buffered feeder of extInst/extInst_en, one instruction per fetch-to-fetch round trip.
module ext_inst_injector #(
    parameter int       DEPTH       = 4,
    parameter logic [3:0] FETCH_STATE = 4'd0,
    parameter int       TIMEOUT_CYC = 64,
    parameter int       CNT_W       = 16
) (
    input logic              clk,
    input logic              rst,
    ext_inst_injector_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT_CYC+1);

    typedef enum logic [1:0] {IDLE, WAIT_START, RUN} state_t;

    state_t           r_state;
    logic [31:0]      r_mem [DEPTH];
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic [TW-1:0]    r_tcnt;
    logic [31:0]      r_inst;
    logic             r_en, r_done, r_err;
    logic [CNT_W-1:0] r_issued;
    logic             w_push, w_done, w_tout, w_pop;
    logic [PW-1:0]    w_rnext;

    assign bus.s_ready     = r_count != CW'(DEPTH);
    assign w_push          = bus.s_valid && bus.s_ready;
    assign w_done          = r_state == RUN && bus.core_state == FETCH_STATE;
    // A completion on the last allowed cycle counts as a completion, not a timeout
    assign w_tout          = !w_done && r_state != IDLE && r_tcnt == TW'(TIMEOUT_CYC-1);
    assign w_pop           = w_done || w_tout;
    assign w_rnext         = r_rptr + 1'b1;
    assign bus.ext_inst    = r_inst;
    assign bus.ext_inst_en = r_en;
    assign bus.busy        = r_state != IDLE;
    assign bus.fifo_count  = r_count;
    assign bus.done_pulse  = r_done;
    assign bus.issued_cnt  = r_issued;
    assign bus.timeout_err = r_err;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.s_inst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_tcnt   <= '0;
            r_inst   <= '0;
            r_en     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_issued <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_push);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_done  <= w_done;
            r_err   <= w_tout || (r_err && !bus.clr_err);
            if (w_done) r_issued <= r_issued + 1'b1;
            case (r_state)
                IDLE: if (r_count != '0) begin
                    r_inst  <= r_mem[r_rptr];
                    r_en    <= 1'b1;
                    r_tcnt  <= '0;
                    r_state <= WAIT_START;
                end
                WAIT_START: if (w_tout) begin
                    r_en    <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    r_tcnt  <= r_tcnt + 1'b1;
                    if (bus.core_state != FETCH_STATE) r_state <= RUN;
                end
                RUN: if (w_done && r_count > CW'(1)) begin
                    r_inst  <= r_mem[w_rnext];
                    r_tcnt  <= '0;
                    r_state <= WAIT_START;
                end else if (w_pop) begin
                    r_en    <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    r_tcnt  <= r_tcnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ext_inst_injector.sv
// tb_ext_inst_injector: directed checks of the injector against a tiny MIPS register model.
module tb_ext_inst_injector;
    logic clk, rst;
    int checks = 0, errors = 0;
    logic [31:0] rf [32];

    ext_inst_injector_if #(.DEPTH(4), .CNT_W(4)) bus();

    ext_inst_injector #(.DEPTH(4), .FETCH_STATE(4'd0), .TIMEOUT_CYC(64), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core round trip: leave fetch, run two cycles, return to fetch; then retire in the model
    task automatic exec();
        logic [31:0] i;
        i = bus.ext_inst;
        bus.core_state = 4'd1;
        repeat (2) tick();
        bus.core_state = 4'd0;
        tick();
        if (i[31:26] == 6'h08 && i[20:16] != 5'd0)
            rf[i[20:16]] = rf[i[25:21]] + {{16{i[15]}}, i[15:0]};
        else if (i[31:26] == 6'h00 && i[5:0] == 6'h20 && i[15:11] != 5'd0)
            rf[i[15:11]] = rf[i[25:21]] + rf[i[20:16]];
    endtask

    task automatic push(input logic [31:0] w);
        bus.s_valid = 1'b1;
        bus.s_inst  = w;
        tick();
        bus.s_valid = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = '0;
        bus.s_valid = 1'b0;
        bus.s_inst = '0;
        bus.core_state = 4'd0;
        bus.clr_err = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_en", bus.ext_inst_en, 0);
        chk("rst_inst", bus.ext_inst, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cnt", bus.fifo_count, 0);
        chk("rst_issued", bus.issued_cnt, 0);
        chk("rst_err", bus.timeout_err, 0);
        #19 rst = 1'b1;
        tick();
        chk("rst_ready", bus.s_ready, 1);

        // single addi
        push(32'h20080005);
        chk("lat1_en", bus.ext_inst_en, 0);
        chk("lat1_cnt", bus.fifo_count, 1);
        tick();
        chk("lat2_inst", bus.ext_inst, 32'h20080005);
        chk("lat2_en", bus.ext_inst_en, 1);
        chk("lat2_busy", bus.busy, 1);
        exec();
        chk("t1_done", bus.done_pulse, 1);
        chk("t1_issued", bus.issued_cnt, 1);
        chk("t1_en", bus.ext_inst_en, 0);
        chk("t1_cnt", bus.fifo_count, 0);
        chk("t1_t0", rf[8], 5);
        tick();
        chk("t1_done_low", bus.done_pulse, 0);
        chk("t1_hold_inst", bus.ext_inst, 32'h20080005);

        // fill with core stalled
        bus.core_state = 4'd1;
        bus.s_valid = 1'b1;
        bus.s_inst = 32'h20090001; tick();
        bus.s_inst = 32'h200A0002; tick();
        bus.s_inst = 32'h200B0003; tick();
        bus.s_inst = 32'h200C0004; tick();
        chk("full_cnt", bus.fifo_count, 4);
        chk("full_ready", bus.s_ready, 0);
        bus.s_inst = 32'h200D0009; tick();
        chk("full_reject", bus.fifo_count, 4);
        bus.s_valid = 1'b0;
        bus.core_state = 4'd0;
        tick();
        rf[9] = 32'd1;
        chk("pop_cnt", bus.fifo_count, 3);
        chk("pop_ready", bus.s_ready, 1);
        chk("pop_next", bus.ext_inst, 32'h200A0002);
        chk("pop_en", bus.ext_inst_en, 1);
        repeat (3) exec();
        chk("drain_cnt", bus.fifo_count, 0);
        chk("drain_en", bus.ext_inst_en, 0);
        chk("drain_issued", bus.issued_cnt, 5);
        chk("drain_t4", rf[12], 4);

        // back-to-back addi then add
        push(32'h20080005);
        push(32'h01084020);
        chk("b2b_first", bus.ext_inst, 32'h20080005);
        chk("b2b_cnt", bus.fifo_count, 2);
        exec();
        chk("b2b_switch", bus.ext_inst, 32'h01084020);
        chk("b2b_en_held", bus.ext_inst_en, 1);
        chk("b2b_done1", bus.done_pulse, 1);
        exec();
        chk("b2b_done2", bus.done_pulse, 1);
        chk("b2b_en_off", bus.ext_inst_en, 0);
        chk("b2b_t0", rf[8], 10);
        chk("b2b_issued", bus.issued_cnt, 7);

        // timeout with core stuck in state 3
        bus.core_state = 4'd3;
        push(32'h20100007);
        tick();
        chk("to_start_en", bus.ext_inst_en, 1);
        repeat (63) tick();
        chk("to_pre_en", bus.ext_inst_en, 1);
        chk("to_pre_err", bus.timeout_err, 0);
        tick();
        chk("to_err", bus.timeout_err, 1);
        chk("to_en", bus.ext_inst_en, 0);
        chk("to_cnt", bus.fifo_count, 0);
        chk("to_busy", bus.busy, 0);
        chk("to_done", bus.done_pulse, 0);
        chk("to_issued", bus.issued_cnt, 7);
        tick();
        chk("to_sticky", bus.timeout_err, 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("to_clr", bus.timeout_err, 0);

        // async reset mid-RUN with 3 queued
        bus.core_state = 4'd1;
        push(32'h20110001);
        push(32'h20120002);
        push(32'h20130003);
        tick();
        chk("ar_pre_cnt", bus.fifo_count, 3);
        chk("ar_pre_en", bus.ext_inst_en, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_en", bus.ext_inst_en, 0);
        chk("ar_cnt", bus.fifo_count, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_issued", bus.issued_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        bus.core_state = 4'd0;
        tick();
        tick();
        chk("ar_post_done", bus.done_pulse, 0);
        chk("ar_post_busy", bus.busy, 0);
        chk("ar_post_cnt", bus.fifo_count, 0);
        chk("ar_post_ready", bus.s_ready, 1);

        // issued_cnt wrap
        for (int n = 0; n < 15; n++) begin
            push(32'h20080001);
            tick();
            exec();
        end
        chk("wrap_max", bus.issued_cnt, 4'hF);
        push(32'h20080001);
        tick();
        exec();
        chk("wrap_zero", bus.issued_cnt, 0);
        chk("wrap_done", bus.done_pulse, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
